pll_reset_sequencer: RTL and testbench

Supervises the HDMI clock PLL from the free-running 100 MHz board clock: pulses the PLL reset, waits for lock, qualifies lock stability, then releases a synchronous reset to the pixel/serializer logic. On lock loss or lock timeout it re-runs the sequence automatically. Optionally it sequences run-time phase steps of the PLL's PSDA input behind a request/acknowledge handshake.

---
 rtl/pll_ctrl_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 35 +++
 rtl/pll_reset_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the HDMI PLL control blocks.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        PHASE     = 3'd4
    } pll_seq_state_t;

    localparam int PSDA_W  = 4;
    localparam int RETRY_W = 8;

    // Larger of two integers, for sizing counters at elaboration time.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs. The synchronous
// clear flushes both stages, so a stale level never survives the clear.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_d, meta_q;
    logic [W-1:0] sync_d, sync_q;

    // Next values for both stages, zeroed while clear is held.
    always_comb begin
        meta_d = clr ? '0 : d;
        sync_d = clr ? '0 : meta_q;
    end

    // Synchronizer stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// HDMI PLL reset/lock supervisor: pulses PLL reset, waits for lock,
// qualifies it, then releases the downstream reset. Re-sequences on lock
// loss or timeout. Optional PSDA phase stepping is built only when the
// PLL_PHASE_CTRL_EN macro is defined.
module pll_reset_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int PHASE_SETTLE  = 64
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [PSDA_W-1:0] pll_psda,
    output logic              rst_out,
    output logic              locked,
    output logic [RETRY_W-1:0] retry_cnt,
    input  logic              phase_req,
    input  logic [PSDA_W-1:0] phase_val,
    output logic              phase_ack
);

    // Counter is wide enough to hold the largest load value itself.
    localparam int MAX_LOAD = max_int(max_int(RST_CYCLES, LOCK_TIMEOUT),
                                      max_int(STABLE_CYCLES, PHASE_SETTLE));
    localparam int CNT_W    = $clog2(MAX_LOAD + 1);

    localparam logic [CNT_W-1:0] LOAD_RST     = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_TIMEOUT = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] LOAD_STABLE  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    pll_seq_state_t      state_d, state_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic [RETRY_W-1:0]  retry_d, retry_q;
    logic                pll_reset_d, pll_reset_q;
    logic                rst_out_d, rst_out_q;
    logic                locked_d, locked_q;
    logic                lock_s;

    // LOCK from a PLL held in reset is meaningless; flush the synchronizer
    // so each sequence starts from a fresh lock observation.
    sync_2ff #(.W(1)) u_lock_sync (
        .clk   (clkin),
        .reset (reset),
        .clr   (pll_reset_q),
        .d     (pll_lock),
        .q     (lock_s)
    );

`ifdef PLL_PHASE_CTRL_EN
    localparam logic [CNT_W-1:0] LOAD_SETTLE = CNT_W'(PHASE_SETTLE);

    logic [PSDA_W-1:0] psda_d, psda_q;
    logic              ack_d, ack_q;
`else
    logic phase_unused;
    assign phase_unused = ^{phase_req, phase_val};
`endif

    // Sequencer next-state, shared counter and registered output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
`ifdef PLL_PHASE_CTRL_EN
        psda_d  = psda_q;
        ack_d   = 1'b0;
`endif
        case (state_q)
            PLL_RST: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = LOAD_TIMEOUT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = LOAD_STABLE;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = PLL_RST;
                    cnt_d   = LOAD_RST;
                    retry_d = (retry_q == '1) ? retry_q : retry_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STABLE: begin
                // A dropout restarts qualification, not the PLL.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = LOAD_TIMEOUT;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RUN: begin
                // Lock loss wins over a same-cycle phase request.
                if (!lock_s) begin
                    state_d = PLL_RST;
                    cnt_d   = LOAD_RST;
                    retry_d = (retry_q == '1) ? retry_q : retry_q + 1'b1;
                end
`ifdef PLL_PHASE_CTRL_EN
                // The ack cycle still sees the old request level; skip it.
                else if (phase_req && !ack_q) begin
                    state_d = PHASE;
                    cnt_d   = LOAD_SETTLE;
                    psda_d  = phase_val;
                end
`endif
            end
`ifdef PLL_PHASE_CTRL_EN
            PHASE: begin
                // Aborted steps are not acked; the held request reruns later.
                if (!lock_s) begin
                    state_d = PLL_RST;
                    cnt_d   = LOAD_RST;
                    retry_d = (retry_q == '1) ? retry_q : retry_q + 1'b1;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = RUN;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = PLL_RST;
                cnt_d   = LOAD_RST;
            end
        endcase

        pll_reset_d = (state_d == PLL_RST);
        rst_out_d   = (state_d != RUN);
        locked_d    = (state_d == RUN);
    end

    // State, counter and output registers.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= PLL_RST;
            cnt_q       <= LOAD_RST;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= 1'b1;
            locked_q    <= 1'b0;
`ifdef PLL_PHASE_CTRL_EN
            psda_q      <= '0;
            ack_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            rst_out_q   <= rst_out_d;
            locked_q    <= locked_d;
`ifdef PLL_PHASE_CTRL_EN
            psda_q      <= psda_d;
            ack_q       <= ack_d;
`endif
        end
    end

    assign pll_reset = pll_reset_q;
    assign rst_out   = rst_out_q;
    assign locked    = locked_q;
    assign retry_cnt = retry_q;
`ifdef PLL_PHASE_CTRL_EN
    assign pll_psda  = psda_q;
    assign phase_ack = ack_q;
`else
    assign pll_psda  = '0;
    assign phase_ack = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small parameters.
// Cycle 0 is the first cycle after the last reset edge; outputs are
// sampled 1 ns after each rising edge.
module tb_pll_reset_sequencer;
    import pll_ctrl_pkg::*;

    logic              clkin = 1'b0;
    logic              reset = 1'b1;
    logic              pll_lock = 1'b0;
    logic              phase_req = 1'b0;
    logic [PSDA_W-1:0] phase_val = '0;
    logic              pll_reset, rst_out, locked, phase_ack;
    logic [PSDA_W-1:0] pll_psda;
    logic [RETRY_W-1:0] retry_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clkin = ~clkin;

    pll_reset_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .PHASE_SETTLE  (5)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .pll_psda  (pll_psda),
        .rst_out   (rst_out),
        .locked    (locked),
        .retry_cnt (retry_cnt),
        .phase_req (phase_req),
        .phase_val (phase_val),
        .phase_ack (phase_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic do_reset(input logic lock);
        reset     = 1'b1;
        pll_lock  = lock;
        phase_req = 1'b0;
        phase_val = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall;
        int ackc;
        int seen;

        // Power-up with lock already high.
        do_reset(1'b1);
        chk("rst_prst",  pll_reset, 1);
        chk("rst_rout",  rst_out,   1);
        chk("rst_lock",  locked,    0);
        chk("rst_psda",  pll_psda,  0);
        chk("rst_ack",   phase_ack, 0);
        chk("rst_retry", retry_cnt, 0);
        fall = -1;
        for (int c = 0; c < 40 && fall < 0; c++) begin
            if (c == 3) chk("pu_prst_c3", pll_reset, 1);
            if (c == 4) chk("pu_prst_c4", pll_reset, 0);
            if (rst_out == 1'b0) fall = c;
            else step();
        end
        chk("pu_release", fall, 15);
        chk("pu_locked", locked, 1);
        chk("pu_retry", retry_cnt, 0);

`ifdef PLL_PHASE_CTRL_EN
        // Phase step 0xA, then a back-to-back request held through the ack.
        phase_req = 1'b1;
        phase_val = 4'hA;
        step();
        chk("ph_psda", pll_psda, 4'hA);
        chk("ph_rout", rst_out, 1);
        chk("ph_lock", locked, 0);
        chk("ph_ack0", phase_ack, 0);
        for (int k = 1; k < 5; k++) begin
            step();
            chk("ph_hold_ack", phase_ack, 0);
            chk("ph_hold_rout", rst_out, 1);
        end
        step();
        chk("ph_ack", phase_ack, 1);
        chk("ph_ack_rout", rst_out, 0);
        chk("ph_ack_lock", locked, 1);
        phase_val = 4'h3;
        step();
        chk("ph_no_early_ack", phase_ack, 0);
        chk("ph_no_early_rout", rst_out, 0);
        step();
        chk("ph2_rout", rst_out, 1);
        chk("ph2_psda", pll_psda, 4'h3);
        phase_req = 1'b0;
        repeat (5) step();
        chk("ph2_ack", phase_ack, 1);
        step();
        chk("ph2_ack_off", phase_ack, 0);

        // Lock drops so that lock_s is low in the 2nd PHASE cycle.
        phase_req = 1'b1;
        phase_val = 4'h5;
        pll_lock  = 1'b0;
        step();
        chk("pa_psda", pll_psda, 4'h5);
        chk("pa_rout", rst_out, 1);
        pll_lock  = 1'b1;
        phase_val = 4'h6;
        step();
        step();
        chk("pa_prst", pll_reset, 1);
        chk("pa_retry", retry_cnt, 1);
        chk("pa_psda_keep", pll_psda, 4'h5);
        ackc = -1;
        for (int n = 2; n < 60 && ackc < 0; n++) begin
            if (n == 17) chk("pa_run", rst_out, 0);
            if (n == 18) chk("pa_psda_new", pll_psda, 4'h6);
            if (phase_ack) ackc = n;
            else step();
        end
        chk("pa_ack_cycle", ackc, 23);
        phase_req = 1'b0;
        step();

        // Reset in the middle of PHASE: no ack, PSDA cleared.
        phase_req = 1'b1;
        phase_val = 4'h9;
        step();
        chk("rp_psda", pll_psda, 4'h9);
        phase_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rp_psda0", pll_psda, 0);
        chk("rp_rout", rst_out, 1);
        chk("rp_prst", pll_reset, 1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (phase_ack) seen = 1;
            step();
        end
        chk("rp_noack", seen, 0);
`else
        // Without phase control the request must be ignored.
        phase_req = 1'b1;
        phase_val = 4'hA;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("np_rout", rst_out, 0);
            chk("np_lock", locked, 1);
            chk("np_psda", pll_psda, 0);
            chk("np_ack", phase_ack, 0);
        end
        phase_req = 1'b0;
`endif

        // Lock loss in RUN: rst_out rises three cycles later.
        do_reset(1'b1);
        repeat (15) step();
        chk("ll_run", rst_out, 0);
        pll_lock = 1'b0;
        step();
        chk("ll_t1", rst_out, 0);
        step();
        chk("ll_t2", rst_out, 0);
        step();
        chk("ll_t3", rst_out, 1);
        chk("ll_prst", pll_reset, 1);
        chk("ll_lock", locked, 0);
        chk("ll_retry", retry_cnt, 1);

        // Relock, then reset mid-STABLE.
        pll_lock = 1'b1;
        repeat (9) step();
        chk("rs_pre_prst", pll_reset, 0);
        chk("rs_pre_rout", rst_out, 1);
        chk("rs_pre_retry", retry_cnt, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rs_prst", pll_reset, 1);
        chk("rs_rout", rst_out, 1);
        chk("rs_lock", locked, 0);
        chk("rs_retry", retry_cnt, 0);
        chk("rs_psda", pll_psda, 0);
        chk("rs_ack", phase_ack, 0);

        // One-cycle lock glitch after 5 STABLE cycles.
        do_reset(1'b1);
        repeat (11) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        fall = -1;
        for (int c = 12; c < 60 && fall < 0; c++) begin
            if (c == 14) chk("gl_c14_rout", rst_out, 1);
            if (rst_out == 1'b0) fall = c;
            else step();
        end
        chk("gl_release", fall, 23);
        chk("gl_retry", retry_cnt, 0);

        // Lock never rises: re-pulse every 24 cycles, saturate at 255.
        do_reset(1'b0);
        for (int c = 0; c <= 24 * 257; c++) begin
            if (c == 23) chk("nl_prst_c23", pll_reset, 0);
            if (c == 24) chk("nl_prst_c24", pll_reset, 1);
            if (c == 24) chk("nl_retry1", retry_cnt, 1);
            if (c == 48) chk("nl_retry2", retry_cnt, 2);
            if (c == 72) chk("nl_retry3", retry_cnt, 3);
            if (c == 24 * 255 - 1) chk("nl_retry254", retry_cnt, 254);
            if (c == 24 * 255) chk("nl_retry255", retry_cnt, 255);
            if (c == 24 * 257) chk("nl_sat", retry_cnt, 255);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
